// File: rtl/load_store_unit.sv
// Load/store unit: accepts one LW/LB/LBU/SW/SB request at a time, validates it,
// drives the data-memory strobes for MEM_LATENCY cycles and returns an extended result.
module load_store_unit #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [17:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_byte_op,
  input  logic [31:0] mem_read_data
);

  localparam int unsigned ADDR_W = 18;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] OP_LW  = 3'b000;
  localparam logic [OP_W-1:0] OP_LB  = 3'b001;
  localparam logic [OP_W-1:0] OP_LBU = 3'b010;
  localparam logic [OP_W-1:0] OP_SW  = 3'b011;
  localparam logic [OP_W-1:0] OP_SB  = 3'b100;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [OP_W-1:0]     r_op;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic                r_mem_read;
  logic                r_mem_write;
  logic                r_byte_op;
  logic                r_req_ready;
  logic                r_resp_valid;

  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [DATA_W-1:0]   w_rdata_nxt;
  logic                w_err_nxt;
  logic                w_mem_read_nxt;
  logic                w_mem_write_nxt;
  logic                w_hs;
  logic                w_req_err;
  logic                w_req_load;
  logic                w_req_store;
  logic                w_req_byte;
  logic [DATA_W-1:0]   w_load_result;

  assign w_hs        = req_valid && (r_state == IDLE);
  assign w_req_load  = (req_op == OP_LW) || (req_op == OP_LB) || (req_op == OP_LBU);
  assign w_req_store = (req_op == OP_SW) || (req_op == OP_SB);
  assign w_req_byte  = (req_op == OP_LB) || (req_op == OP_LBU) || (req_op == OP_SB);
  assign w_req_err   = (req_op > OP_SB) || (req_addr[31:ADDR_W] != '0) ||
                       (((req_op == OP_LW) || (req_op == OP_SW)) && (req_addr[1:0] != 2'b00));

  // Byte reads only carry meaning in bits [7:0].
  always_comb begin
    w_load_result = '0;
    case (r_op)
      OP_LW:   w_load_result = mem_read_data;
      OP_LB:   w_load_result = {{24{mem_read_data[7]}}, mem_read_data[7:0]};
      OP_LBU:  w_load_result = {24'b0, mem_read_data[7:0]};
      default: w_load_result = '0;
    endcase
  end

  // Next-state, counter, strobe and response logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_rdata_nxt     = r_rdata;
    w_err_nxt       = r_err;
    w_mem_read_nxt  = 1'b0;
    w_mem_write_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_err_nxt   = w_req_err;
          w_rdata_nxt = '0;
          if (w_req_err) begin
            w_state_nxt = RESP;
          end else begin
            w_state_nxt     = ACCESS;
            w_cnt_nxt       = CNT_W'(MEM_LATENCY);
            w_mem_read_nxt  = w_req_load;
            w_mem_write_nxt = w_req_store;
          end
        end
      end
      ACCESS: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = RESP;
          w_cnt_nxt   = '0;
          w_rdata_nxt = w_load_result;
        end else begin
          w_cnt_nxt       = r_cnt - CNT_W'(1);
          w_mem_read_nxt  = r_mem_read;
          w_mem_write_nxt = r_mem_write;
        end
      end
      RESP: begin
        if (resp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_op         <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_byte_op    <= 1'b0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_rdata      <= w_rdata_nxt;
      r_err        <= w_err_nxt;
      r_mem_read   <= w_mem_read_nxt;
      r_mem_write  <= w_mem_write_nxt;
      r_req_ready  <= (w_state_nxt == IDLE);
      r_resp_valid <= (w_state_nxt == RESP);
      if (w_hs) begin
        r_op      <= req_op;
        r_addr    <= req_addr[ADDR_W-1:0];
        r_byte_op <= w_req_byte;
        r_wdata   <= (req_op == OP_SB) ? {24'b0, req_wdata[7:0]} : req_wdata;
      end
    end
  end

  assign req_ready      = r_req_ready;
  assign resp_valid     = r_resp_valid;
  assign resp_rdata     = r_rdata;
  assign resp_err       = r_err;
  assign mem_address    = r_addr;
  assign mem_write_data = r_wdata;
  assign mem_read       = r_mem_read;
  assign mem_write      = r_mem_write;
  assign mem_byte_op    = r_byte_op;

endmodule
